if_id_fetch_buffer: RTL and testbench

//   IF->ID decoupling stage. Sits directly downstream of the 1-cycle registered instruction memory.
//   Re-pairs each returning instruction with the PC that fetched it, buffers up to DEPTH entries,
//   and hands them to decode on a valid/ready handshake.

---
 rtl/rv32_pipe_pkg.sv | 13 +
 rtl/ifid_entry_fifo.sv | 48 ++++
 rtl/if_id_fetch_buffer.sv | 99 +++++++++
 tb/tb_if_id_fetch_buffer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pipe_pkg.sv
// Shared RV32 pipeline types: datapath width, the canonical NOP and the
// instruction/PC pair that travels from fetch to decode.
package rv32_pipe_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INS = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifid_entry_fifo.sv
// DEPTH-entry FIFO of fetch_entry_t with a registered head slot,
// synchronous clear and an occupancy count one bit wider than the pointers.
module ifid_entry_fifo
    import rv32_pipe_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    input  logic                   clear,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_id_fetch_buffer.sv
// IF->ID decoupling buffer: pairs imem data with its fetch PC, buffers DEPTH
// entries for decode. Optional perf counters under IF_ID_PERF_EN.
module if_id_fetch_buffer #(
    parameter int          XLEN    = rv32_pipe_pkg::XLEN,
    parameter int          DEPTH   = 2,
    parameter logic [31:0] NOP_INS = rv32_pipe_pkg::NOP_INS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_req,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            fetch_ready,
    input  logic [31:0]     imem_instr,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic            id_misalign
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]     perf_stall_cyc,
    output logic [31:0]     perf_flush_cnt
`endif
);

    import rv32_pipe_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;

    logic            inflight;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] last_pc;
    logic [CW-1:0]   count;
    logic [OW-1:0]   occupancy;
    logic            push;
    logic            pop;
    logic            fetch_fire;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    // An in-flight return landing in a flush cycle is stale and must be dropped.
    assign push       = inflight & ~flush;
    assign pop        = id_valid & id_ready;
    assign occupancy  = OW'(count) + OW'(inflight) - OW'(pop);
    assign fetch_ready = flush | (occupancy < OW'(DEPTH));
    assign fetch_fire = fetch_req & fetch_ready;
    assign push_entry = '{instr: imem_instr, pc: pc_q};

    ifid_entry_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .clear      (flush),
        .head       (head),
        .count      (count)
    );

    // last_pc keeps id_pc stable once the buffer drains.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= 1'b0;
            pc_q     <= '0;
            last_pc  <= '0;
        end else begin
            inflight <= fetch_fire;
            if (fetch_fire) pc_q    <= fetch_pc;
            if (id_valid)   last_pc <= head.pc;
        end
    end

    assign id_valid    = (count != '0);
    assign id_instr    = id_valid ? head.instr : NOP_INS;
    assign id_pc       = id_valid ? head.pc : last_pc;
    assign id_pc_plus4 = id_pc + XLEN'(4);
    assign id_misalign = id_valid & (id_pc[1:0] != 2'b00);

`ifdef IF_ID_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (fetch_req && !fetch_ready && perf_stall_cyc != '1)
                perf_stall_cyc <= perf_stall_cyc + 1'b1;
            if (flush && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Directed self-checking bench for if_id_fetch_buffer with a registered imem model.
// Perf counter checks are compiled in when IF_ID_PERF_EN is defined.
module tb_if_id_fetch_buffer;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic [31:0] imem_instr;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_misalign;
`ifdef IF_ID_PERF_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush_cnt;
`endif

    int checks;
    int errors;

    if_id_fetch_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .imem_instr  (imem_instr),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_misalign (id_misalign)
`ifdef IF_ID_PERF_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0003;
    endfunction

    // Imem returns data for the address presented one cycle earlier.
    always @(posedge clk) imem_instr <= mk_instr(fetch_pc);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [31:0] pc, input logic rdy, input logic fl);
        fetch_req = req;
        fetch_pc  = pc;
        id_ready  = rdy;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);

        // Reset held with a fetch request pending
        @(negedge clk);
        checkOutput("rst_valid", 32'(id_valid), 32'd0);
        checkOutput("rst_instr", id_instr, 32'h13);
        checkOutput("rst_pc", id_pc, 32'h0);
        checkOutput("rst_pc4", id_pc_plus4, 32'h4);
        checkOutput("rst_misalign", 32'(id_misalign), 32'd0);
        checkOutput("rst_ready", 32'(fetch_ready), 32'd1);
        step();
        checkOutput("rst_hold_valid", 32'(id_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        step();
        checkOutput("rst_no_push", 32'(id_valid), 32'd0);

        // Streaming 0,4,8 with decode always ready
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0);
        step();
        checkOutput("str_lat1_valid", 32'(id_valid), 32'd0);
        applyStimulus(1'b1, 32'h4, 1'b1, 1'b0);
        step();
        checkOutput("str0_valid", 32'(id_valid), 32'd1);
        checkOutput("str0_pc", id_pc, 32'h0);
        checkOutput("str0_instr", id_instr, mk_instr(32'h0));
        checkOutput("str0_pc4", id_pc_plus4, 32'h4);
        applyStimulus(1'b1, 32'h8, 1'b1, 1'b0);
        step();
        checkOutput("str1_pc", id_pc, 32'h4);
        checkOutput("str1_instr", id_instr, mk_instr(32'h4));
        checkOutput("str1_pc4", id_pc_plus4, 32'h8);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        checkOutput("str2_valid", 32'(id_valid), 32'd1);
        checkOutput("str2_pc", id_pc, 32'h8);
        checkOutput("str2_pc4", id_pc_plus4, 32'hC);
        step();
        checkOutput("str_empty_valid", 32'(id_valid), 32'd0);
        checkOutput("str_empty_instr", id_instr, 32'h13);
        checkOutput("str_empty_pc_hold", id_pc, 32'h8);

        // Back-pressure: decode stalled, fetch every cycle
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
        #1 checkOutput("bp_ready0", 32'(fetch_ready), 32'd1);
        step();
        applyStimulus(1'b1, 32'h14, 1'b0, 1'b0);
        #1 checkOutput("bp_ready1", 32'(fetch_ready), 32'd1);
        step();
        applyStimulus(1'b1, 32'h18, 1'b0, 1'b0);
        #1 checkOutput("bp_ready_drop", 32'(fetch_ready), 32'd0);
        step();
        checkOutput("bp_full_pc", id_pc, 32'h10);
        checkOutput("bp_full_ready", 32'(fetch_ready), 32'd0);
        step();
        checkOutput("bp_hold_pc", id_pc, 32'h10);
        checkOutput("bp_hold_instr", id_instr, mk_instr(32'h10));
        applyStimulus(1'b1, 32'h18, 1'b1, 1'b0);
        #1 checkOutput("bp_pop_ready", 32'(fetch_ready), 32'd1);
        step();
        checkOutput("bp_drain1_pc", id_pc, 32'h14);
        checkOutput("bp_drain1_instr", id_instr, mk_instr(32'h14));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        checkOutput("bp_drain2_pc", id_pc, 32'h18);
        checkOutput("bp_drain2_instr", id_instr, mk_instr(32'h18));
        step();
        checkOutput("bp_drained", 32'(id_valid), 32'd0);

        // Flush with one buffered and one in flight, redirect to 0x100
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h24, 1'b0, 1'b0);
        step();
        checkOutput("fl_pre_pc", id_pc, 32'h20);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
        #1 checkOutput("fl_ready", 32'(fetch_ready), 32'd1);
        step();
        checkOutput("fl_valid_off", 32'(id_valid), 32'd0);
        checkOutput("fl_instr_nop", id_instr, 32'h13);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        checkOutput("fl_target_valid", 32'(id_valid), 32'd1);
        checkOutput("fl_target_pc", id_pc, 32'h100);
        checkOutput("fl_target_instr", id_instr, mk_instr(32'h100));
        step();
        checkOutput("fl_only_target", 32'(id_valid), 32'd0);

        // Flush of a full buffer with no redirect fetch
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h204, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        checkOutput("fl2_full_pc", id_pc, 32'h200);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        checkOutput("fl2_valid_off", 32'(id_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        checkOutput("fl2_stays_empty", 32'(id_valid), 32'd0);

        // PC wrap and misalignment
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h102, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("wrap_pc", id_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_pc4", id_pc_plus4, 32'h0);
        checkOutput("wrap_aligned", 32'(id_misalign), 32'd0);
        step();
        checkOutput("mis_pc", id_pc, 32'h102);
        checkOutput("mis_flag", 32'(id_misalign), 32'd1);
        checkOutput("mis_pc4", id_pc_plus4, 32'h106);
        step();

        // Asynchronous reset between edges with two entries held
        applyStimulus(1'b1, 32'h30, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h34, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        checkOutput("arst_pre_valid", 32'(id_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(id_valid), 32'd0);
        checkOutput("arst_instr", id_instr, 32'h13);
        checkOutput("arst_pc", id_pc, 32'h0);
        checkOutput("arst_ready", 32'(fetch_ready), 32'd1);
`ifdef IF_ID_PERF_EN
        checkOutput("perf_rst_stall", perf_stall_cyc, 32'd0);
        checkOutput("perf_rst_flush", perf_flush_cnt, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        step();
        step();
        checkOutput("arst_inflight_lost", 32'(id_valid), 32'd0);

`ifdef IF_ID_PERF_EN
        // Five stalled fetch cycles, then a single flush cycle
        applyStimulus(1'b1, 32'h50, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h54, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 32'h58, 1'b0, 1'b0);
        repeat (5) step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("perf_stall5", perf_stall_cyc, 32'd5);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("perf_flush1", perf_flush_cnt, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
